// File: rtl/wdt_rst_ctrl.sv
// Watchdog reset controller: stretches power-on and watchdog resets,
// records reset cause and count, and gates the pre-timeout interrupt.
module wdt_rst_ctrl #(
  parameter int unsigned RST_CYCLES = 16,
  parameter int unsigned HOLDOFF    = 4
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       timeout,
  input  logic       intr,
  input  logic       irq_en,
  input  logic       irq_clr,
  input  logic       cause_clr,
  output logic       sys_rst_,
  output logic       irq,
  output logic       cause_wdt,
  output logic [7:0] rst_count,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RECOVER
  } state_t;

  localparam logic [7:0] RST_LD = 8'(RST_CYCLES);
  localparam logic [7:0] HO_LD  = 8'(HOLDOFF);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       sys_rst_q, sys_rst_d;
  logic       timeout_d, intr_d;
  logic       pending_q, pending_d;
  logic       cause_q, cause_d;
  logic [7:0] count_q, count_d;
  logic       hold_entry;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sys_rst_d  = sys_rst_q;
    hold_entry = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (timeout && !timeout_d) begin
          state_d    = HOLD;
          cnt_d      = RST_LD;
          sys_rst_d  = 1'b0;
          hold_entry = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd1) begin
          state_d   = RECOVER;
          cnt_d     = HO_LD;
          sys_rst_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RECOVER: begin
        if (cnt_q == 8'd1) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = 8'd0;
        sys_rst_d = 1'b1;
      end
    endcase
  end

  // Hold entry beats a same-cycle intr edge; a set beats irq_clr.
  always_comb begin
    pending_d = pending_q;
    if (hold_entry) begin
      pending_d = 1'b0;
    end else if (intr && !intr_d && state_q != HOLD) begin
      pending_d = 1'b1;
    end else if (irq_clr) begin
      pending_d = 1'b0;
    end
  end

  always_comb begin
    cause_d = cause_q;
    count_d = count_q;
    if (hold_entry) begin
      cause_d = 1'b1;
      if (cause_clr) begin
        count_d = 8'd1;
      end else if (count_q != 8'hff) begin
        count_d = count_q + 8'd1;
      end
    end else if (cause_clr) begin
      cause_d = 1'b0;
      count_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q   <= HOLD;
      cnt_q     <= RST_LD;
      sys_rst_q <= 1'b0;
      timeout_d <= 1'b0;
      intr_d    <= 1'b0;
      pending_q <= 1'b0;
      cause_q   <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sys_rst_q <= sys_rst_d;
      timeout_d <= timeout;
      intr_d    <= intr;
      pending_q <= pending_d;
      cause_q   <= cause_d;
      count_q   <= count_d;
    end
  end

  assign sys_rst_  = sys_rst_q;
  assign busy      = (state_q != IDLE);
  assign irq       = pending_q & irq_en;
  assign cause_wdt = cause_q;
  assign rst_count = count_q;

endmodule

// File: tb/tb_wdt_rst_ctrl.sv
// Testbench for wdt_rst_ctrl: vector table with expectation queue,
// plus hand sequences for reset stretching, saturation and rst_ abort.
module tb_wdt_rst_ctrl;

  logic       clk;
  logic       rst_;
  logic       timeout;
  logic       intr;
  logic       irq_en;
  logic       irq_clr;
  logic       cause_clr;
  logic       sys_rst_;
  logic       irq;
  logic       cause_wdt;
  logic [7:0] rst_count;
  logic       busy;

  int pass_cnt = 0;
  int total    = 0;

  typedef struct {
    logic       intr;
    logic       en;
    logic       clr;
    logic       to;
    logic       irq;
    logic       busy;
    logic       cause;
    logic [7:0] cnt;
  } vec_t;

  typedef struct {
    logic       irq;
    logic       busy;
    logic       cause;
    logic [7:0] cnt;
  } exp_t;

  vec_t vecs[15];
  exp_t sb[$];

  wdt_rst_ctrl dut (
    .clk(clk),
    .rst_(rst_),
    .timeout(timeout),
    .intr(intr),
    .irq_en(irq_en),
    .irq_clr(irq_clr),
    .cause_clr(cause_clr),
    .sys_rst_(sys_rst_),
    .irq(irq),
    .cause_wdt(cause_wdt),
    .rst_count(rst_count),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy && k < 60) begin
      step();
      k++;
    end
    chk(nm, int'(busy), 0);
  endtask

  initial begin
    int k;
    int low;
    int falls;
    int bsy;
    logic prev;
    exp_t e;

    vecs[0]  = '{1, 1, 0, 0, 1, 0, 1, 8'd1};
    vecs[1]  = '{0, 1, 0, 0, 1, 0, 1, 8'd1};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 1, 8'd1};
    vecs[3]  = '{0, 1, 0, 0, 1, 0, 1, 8'd1};
    vecs[4]  = '{0, 1, 1, 0, 0, 0, 1, 8'd1};
    vecs[5]  = '{1, 1, 0, 0, 1, 0, 1, 8'd1};
    vecs[6]  = '{0, 1, 0, 0, 1, 0, 1, 8'd1};
    vecs[7]  = '{0, 1, 1, 0, 0, 0, 1, 8'd1};
    vecs[8]  = '{0, 1, 0, 0, 0, 0, 1, 8'd1};
    vecs[9]  = '{1, 1, 1, 0, 1, 0, 1, 8'd1};
    vecs[10] = '{0, 1, 1, 0, 0, 0, 1, 8'd1};
    vecs[11] = '{1, 1, 0, 1, 0, 1, 1, 8'd2};
    vecs[12] = '{0, 1, 0, 1, 0, 1, 1, 8'd2};
    vecs[13] = '{1, 1, 0, 1, 0, 1, 1, 8'd2};
    vecs[14] = '{0, 1, 0, 1, 0, 1, 1, 8'd2};

    rst_      = 1'b1;
    timeout   = 1'b0;
    intr      = 1'b0;
    irq_en    = 1'b1;
    irq_clr   = 1'b0;
    cause_clr = 1'b0;
    #1 rst_ = 1'b0;
    #2;
    chk("rst_sys_rst_", int'(sys_rst_), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_irq", int'(irq), 0);
    chk("rst_cause", int'(cause_wdt), 0);
    chk("rst_count", int'(rst_count), 0);
    repeat (3) step();
    chk("rst_held_sys", int'(sys_rst_), 0);

    // power-on stretching
    rst_ = 1'b1;
    k = 0;
    while (!sys_rst_ && k < 100) begin
      step();
      k++;
    end
    chk("por_low_cycles", k, 16);
    while (busy && k < 100) begin
      step();
      k++;
    end
    chk("por_busy_cycles", k, 20);
    chk("por_cause", int'(cause_wdt), 0);
    chk("por_count", int'(rst_count), 0);

    // long timeout level: single reset
    timeout = 1'b1;
    low   = 0;
    falls = 0;
    bsy   = 0;
    prev  = 1'b1;
    for (int i = 0; i < 45; i++) begin
      step();
      if (!sys_rst_) low++;
      if (prev && !sys_rst_) falls++;
      if (busy) bsy++;
      prev = sys_rst_;
      if (i == 39) timeout = 1'b0;
    end
    chk("wdt_low_cycles", low, 16);
    chk("wdt_falls", falls, 1);
    chk("wdt_busy_cycles", bsy, 20);
    chk("wdt_cause", int'(cause_wdt), 1);
    chk("wdt_count", int'(rst_count), 1);

    // interrupt vectors, expectations queued at drive time
    for (int i = 0; i < 15; i++) begin
      intr    = vecs[i].intr;
      irq_en  = vecs[i].en;
      irq_clr = vecs[i].clr;
      timeout = vecs[i].to;
      sb.push_back('{vecs[i].irq, vecs[i].busy,
                     vecs[i].cause, vecs[i].cnt});
      step();
      e = sb.pop_front();
      chk($sformatf("v%0d_irq", i), int'(irq), int'(e.irq));
      chk($sformatf("v%0d_busy", i), int'(busy), int'(e.busy));
      chk($sformatf("v%0d_cause", i), int'(cause_wdt), int'(e.cause));
      chk($sformatf("v%0d_cnt", i), int'(rst_count), int'(e.cnt));
    end
    irq_clr = 1'b0;

    // intr edge accepted in RECOVER
    k = 0;
    while (!sys_rst_ && k < 40) begin
      step();
      k++;
    end
    chk("reach_recover", int'(sys_rst_ && busy), 1);
    intr = 1'b1;
    step();
    chk("recover_irq", int'(irq), 1);
    intr    = 1'b0;
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    chk("recover_irq_clr", int'(irq), 0);

    // timeout still high at IDLE must not retrigger
    wait_idle("idle_after_hold");
    repeat (5) step();
    chk("no_retrigger_busy", int'(busy), 0);
    chk("no_retrigger_cnt", int'(rst_count), 2);
    timeout = 1'b0;

    cause_clr = 1'b1;
    step();
    cause_clr = 1'b0;
    chk("clr_cause", int'(cause_wdt), 0);
    chk("clr_count", int'(rst_count), 0);

    // saturation
    for (int i = 0; i < 256; i++) begin
      timeout = 1'b1;
      step();
      timeout = 1'b0;
      wait_idle("sat_idle");
    end
    chk("sat_count", int'(rst_count), 255);
    chk("sat_cause", int'(cause_wdt), 1);

    timeout   = 1'b1;
    cause_clr = 1'b1;
    step();
    timeout   = 1'b0;
    cause_clr = 1'b0;
    chk("clr_hold_count", int'(rst_count), 1);
    chk("clr_hold_cause", int'(cause_wdt), 1);
    chk("clr_hold_busy", int'(busy), 1);
    wait_idle("clr_hold_idle");

    timeout = 1'b1;
    step();
    timeout = 1'b0;
    wait_idle("second_idle");
    chk("second_count", int'(rst_count), 2);

    // rst_ during HOLD
    timeout = 1'b1;
    step();
    timeout = 1'b0;
    repeat (3) step();
    chk("pre_abort_count", int'(rst_count), 3);
    chk("pre_abort_sys", int'(sys_rst_), 0);
    #2 rst_ = 1'b0;
    #1;
    chk("abort_count", int'(rst_count), 0);
    chk("abort_cause", int'(cause_wdt), 0);
    chk("abort_sys", int'(sys_rst_), 0);
    step();
    rst_ = 1'b1;
    k = 0;
    while (!sys_rst_ && k < 100) begin
      step();
      k++;
    end
    chk("abort_low_cycles", k, 16);
    wait_idle("abort_idle");
    chk("abort_end_count", int'(rst_count), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
